// File: rtl/neuron_mac_pkg.sv
// Fixed-point definitions shared by the neuron datapath blocks.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package neuron_mac_pkg;

  // Number of fractional bits in a Q8.8 word; products and sums are Q16.16.
  localparam int FRAC_BITS = 8;

  // Neuron sequencing states.
  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,  // accepting input beats
    ST_WAIT = 2'd1,  // last product drains into the accumulator
    ST_BIAS = 2'd2   // bias added, result registered, accumulator cleared
  } state_t;

endpackage

// File: rtl/neuron_mac_sat_add.sv
// Signed two's-complement adder that clamps to the most positive/negative W-bit value.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: a, b - signed W-bit operands; y - saturated signed W-bit sum.
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] sum;

  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    y   = sum[W-1:0];
    // The extra sign bit disagrees with the result MSB only on overflow;
    // its value tells which direction we overflowed.
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate: sums x*w over one input vector, adds bias, emits Q16.16 pre-activation.
// Latency: sum_valid is high after the 3rd clock edge counting the edge that accepts the last beat.
// Backpressure: in_ready low for the two cycles after the last beat (WAIT, BIAS); no output backpressure.
// Ports: clk/rst_n - clock and async active-low reset;
//        in_valid/in_ready/in_last/x/w - input beat handshake and Q8.8 operands;
//        bias - Q8.8 bias, sampled in BIAS; sum_out/sum_valid - Q16.16 result and one-cycle qualifier.
import neuron_mac_pkg::*;

module neuron_mac #(
  parameter int dataWidth = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [dataWidth-1:0]     x,
  input  logic [dataWidth-1:0]     w,
  input  logic [dataWidth-1:0]     bias,
  output logic [2*dataWidth-1:0]   sum_out,
  output logic                     sum_valid
);

  localparam int AW = 2 * dataWidth;

  state_t        state_q, state_d;
  logic          prod_vld_q, prod_vld_d;
  logic          prod_last_q, prod_last_d;
  logic [AW-1:0] prod_q, prod_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          sum_vld_q, sum_vld_d;

  logic          accept;
  logic [AW-1:0] x_ext, w_ext, product;
  logic [AW-1:0] bias_ext;
  logic [AW-1:0] acc_sum, bias_sum;

  assign in_ready = (state_q == ST_ACC);
  assign accept   = in_valid & in_ready;

  // Sign-extend both operands to full width so the truncated product is the
  // exact signed Q16.16 result.
  assign x_ext   = {{dataWidth{x[dataWidth-1]}}, x};
  assign w_ext   = {{dataWidth{w[dataWidth-1]}}, w};
  assign product = $signed(x_ext) * $signed(w_ext);

  // Q8.8 bias aligned to the Q16.16 accumulator: sign-extend, shift left by
  // the fractional bit count.
  assign bias_ext = {{(dataWidth-FRAC_BITS){bias[dataWidth-1]}}, bias, {FRAC_BITS{1'b0}}};

  sat_add #(.W(AW)) u_acc_add (
    .a (acc_q),
    .b (prod_q),
    .y (acc_sum)
  );

  sat_add #(.W(AW)) u_bias_add (
    .a (acc_q),
    .b (bias_ext),
    .y (bias_sum)
  );

  always_comb begin
    state_d     = state_q;
    prod_vld_d  = accept;
    prod_last_d = accept & in_last;
    prod_d      = prod_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_vld_d   = 1'b0;

    if (accept) begin
      prod_d = product;
    end

    if (prod_vld_q) begin
      acc_d = acc_sum;
    end

    case (state_q)
      ST_ACC: begin
        if (accept && in_last) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // WAIT is entered on the edge that registers the last product, so the
        // stage always holds it here; this edge folds it into acc.
        if (prod_vld_q && prod_last_q) begin
          state_d = ST_BIAS;
        end
      end
      ST_BIAS: begin
        // No beat is accepted in WAIT, so the product stage is empty and acc
        // is final; clearing it here cannot drop a product.
        sum_d     = bias_sum;
        sum_vld_d = 1'b1;
        acc_d     = '0;
        state_d   = ST_ACC;
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_vld_q  <= prod_vld_d;
      prod_last_q <= prod_last_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_vld_q   <= sum_vld_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = sum_vld_q;

endmodule

// File: doc/neuron_mac.md
NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter dataWidth, default 16, meaning the width of signed Q8.8 input, weight and bias words.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  x/w/in_last beat is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-006 SHALL have port in_last  input  1  final beat of the current neuron's input vector.
REQ-007 SHALL have port x  input  dataWidth  signed Q8.8 activation.
REQ-008 SHALL have port w  input  dataWidth  signed Q8.8 weight.
REQ-009 SHALL have port bias  input  dataWidth  signed Q8.8 bias, sampled in BIAS state.
REQ-010 SHALL have port sum_out  output  2*dataWidth  signed Q16.16 pre-activation sum, for the downstream ReLU stage.
REQ-011 SHALL have port sum_valid  output  1  one-cycle pulse qualifying sum_out.

Function
REQ-012 SHALL implement states ACC, WAIT, BIAS.
REQ-013 SHALL drive in_ready=1 only in ACC; a beat is accepted when in_valid & in_ready are both high at a clock edge.
REQ-014 SHALL register each accepted beat's full signed product x*w (2*dataWidth bits, Q16.16) plus the product's last flag in a one-deep product stage.
REQ-015 SHALL, on the edge after a product is registered, update acc <= sat(acc + product).
REQ-016 SHALL define sat() as signed saturation to 2*dataWidth bits: positive overflow -> 0x7FFFFFFF, negative overflow -> 0x80000000 (for dataWidth=16).
REQ-017 SHALL transition ACC->WAIT on acceptance of a beat with in_last=1.
REQ-018 SHALL transition WAIT->BIAS unconditionally after one cycle, so that the last product has been accumulated.
REQ-019 SHALL, in BIAS, register sum_out <= sat(acc + (sign-extended bias << 8)), assert sum_valid on the following cycle, clear acc to 0, and return to ACC.
REQ-020 SHALL produce a latency of 3 edges from acceptance of the last beat to sum_valid being high, with sum_valid high for exactly one cycle.
REQ-021 SHALL hold sum_out stable until the next BIAS update.
REQ-022 SHALL allow a single-beat neuron (first beat carries in_last).
REQ-023 SHALL accept a beat for the next neuron in the same cycle sum_valid is high (in_ready=1 in ACC).
REQ-024 SHALL ignore in_valid while in_ready=0, with no beat lost or duplicated.
REQ-025 SHALL apply no backpressure on the output side; the consumer samples sum_out when sum_valid is high.

Reset
REQ-026 SHALL, while rst_n=0, force state=ACC, acc=0, product stage empty, sum_out=0, sum_valid=0, in_ready=1 (in_ready as soon as rst_n deasserts).
REQ-027 SHALL discard any partially accumulated neuron on reset assertion mid-operation and emit no sum_valid for it.

Structure
REQ-028 SHALL place the state encoding and the Q8.8 fractional-bit constant (8) in a shared fixed-point package used by the neuron-datapath blocks.
REQ-029 SHALL implement the saturating adder as one sub-module, sat_add, instantiated for both the accumulate and bias paths.

Verification
REQ-030 SHALL verify two beats x=0x0100/w=0x0200 and x=0x0100/w=0x0100 (last), bias=0x0080 -> sum_out=0x00038000, one sum_valid pulse 3 edges after last accept.
REQ-031 SHALL verify three beats x=w=0x7FFF, bias=0 -> sum_out=0x7FFFFFFF (positive saturation at third accumulate).
REQ-032 SHALL verify three beats x=0x8000/w=0x7FFF, bias=0 -> sum_out=0x80000000 (negative saturation).
REQ-033 SHALL verify a single beat x=0xFF00 (-1.0), w=0x0100, bias=0x0000 -> sum_out=0xFFFF0000; then back-to-back neuron beat accepted in the sum_valid cycle accumulating from 0.
REQ-034 SHALL verify rst_n pulsed low after 2 of 4 beats -> no sum_valid; a following 1-beat neuron x=w=0x0100 -> sum_out=0x00010000.
REQ-035 SHALL verify random in_valid gaps give a result identical to gapless streaming, and that in_ready=0 in WAIT and BIAS.
